clk_ratio_meter: RTL and testbench
==================================

Name: clk_ratio_meter

Overview:
- Receiving end of the clock-divider interface: observes a divided clock (sig_in) in the clk domain and measures its period and high time in clk cycles.
- Reports each completed measurement with a one-cycle valid pulse, plus lock and overflow status.
- Sits beside the clock divider as a self-check and readback path for the programmed divide ratio.

Parameters:
- WIDTH, `DATA_WIDTH, width of the period/high-time counters and outputs.

Ports:
- clk  input  1  system clock; sole clock.
- reset  input  1  synchronous, active-high reset.
- sig_in  input  1  divided clock under measurement; synchronous to clk unless RATIO_SYNC_EN is defined.
- period  output  WIDTH  last measured rising-to-rising period, in clk cycles.
- high_time  output  WIDTH  clk cycles sig_in was sampled high within that period.
- ratio_valid  output  1  one-cycle pulse when period/high_time update.
- locked  output  1  two consecutive valid periods are equal.
- overflow  output  1  period exceeded counter range; sticky until the next valid measurement.

Behaviour:
- Reset values: all outputs 0, state IDLE, cnt 0, hcnt 0, sig_d 0, prev_period 0.
- Edge detect: rise = sig_in & ~sig_d; sig_d is registered sig_in.
- Counter: on rise, cnt <= 1; otherwise cnt increments, saturating at 2^WIDTH-1.
- Period value: with rises at cycles t0 and t0+P, cnt equals P in cycle t0+P.
- High time: hcnt counts cycles with sig_in=1; on rise, hcnt <= 1.
- States:
  - IDLE: no reference edge yet. On rise -> MEASURE; no valid pulse.
  - MEASURE, on rise: period <= cnt, high_time <= hcnt, ratio_valid <= 1 for one cycle, overflow <= 0; stay in MEASURE.
  - MEASURE, cnt reaches 2^WIDTH-1 with no rise: -> OVF, overflow <= 1, locked <= 0.
  - OVF: counters held saturated. On rise -> MEASURE with counters restarted; no valid pulse, since that period is invalid.
- Latency: period and ratio_valid are visible the cycle after the cycle in which rise is detected.
- Lock rule: on each valid update, locked <= (cnt == prev_period) and prev_period <= cnt. Any mismatch clears locked immediately.
- Minimum measurable period is 2. sig_in held at constant 0 or 1 leads to OVF after 2^WIDTH-1 cycles.
- Rise coincident with saturation: the rise wins. The measurement is valid with period = 2^WIDTH-1, and the state stays MEASURE.
- Reset mid-measurement: everything returns to IDLE. The first rise after reset only arms; no valid pulse.
- period and high_time hold their last value between pulses.

Optional Feature:
- Macro: RATIO_SYNC_EN.
- Defined: sig_in passes through a 2-flop synchronizer before the edge detect, so sig_in may be asynchronous. All event latencies grow by 2 cycles; measured values are unchanged for a stable input.
- Undefined: sig_in is sampled directly with no synchronizer.

Decomposition:
- includes.vh (shared):
  - State encodings `RM_IDLE=2'd0, `RM_MEASURE=2'd1, `RM_OVF=2'd2.
  - Reuses `DATA_WIDTH.
- Sub-module rise_detect: optional synchronizer plus sig_d register; outputs the registered level and the rise pulse.
- FSM, counters and lock logic stay in clk_ratio_meter.

Test Plan:
- Reset, then a square wave with 3 cycles high / 3 low -> first rise gives no pulse; every following rise gives ratio_valid with period=6, high_time=3. locked=1 from the second valid pulse onward.
- Wave switched to 2 high / 2 low mid-run -> first new valid gives period=4 with locked=0; next gives period=4 with locked=1.
- sig_in held at 0 for 300 cycles, WIDTH=8 -> overflow=1 at cnt=255, locked=0, no valid pulse. Next rise gives no pulse. Following rise with period 6 gives ratio_valid, period=6, overflow=0.
- Reset asserted for 1 cycle mid-period with period 10 running -> outputs 0 next cycle. The next rise only arms; the following rise gives period=10.
- Minimum-period toggle (1 high / 1 low) -> period=2, high_time=1 on every rise after arming.
- With RATIO_SYNC_EN defined, repeat scenario 1 -> same values, ratio_valid delayed by 2 cycles relative to the undefined build.

Source files
------------

// File: rtl/clk_ratio_meter_pkg.sv
// Shared types and constants for the clock ratio meter.
package clk_ratio_meter_pkg;

    // Default width of the period and high-time counters
    localparam int unsigned DATA_WIDTH = 8;

    // Measurement FSM encoding
    typedef enum logic [1:0] {
        RM_IDLE    = 2'd0,
        RM_MEASURE = 2'd1,
        RM_OVF     = 2'd2
    } rm_state_e;

endpackage : clk_ratio_meter_pkg

// File: rtl/clk_ratio_meter_if.sv
// Bus between the divided-clock source and the ratio meter.
interface clk_ratio_meter_if
    import clk_ratio_meter_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH
);
    logic             sig_in;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_time;
    logic             ratio_valid;
    logic             locked;
    logic             overflow;

    // Source side: drives the divided clock, reads back measurements
    modport master (
        output sig_in,
        input  period,
        input  high_time,
        input  ratio_valid,
        input  locked,
        input  overflow
    );

    // Meter side
    modport slave (
        input  sig_in,
        output period,
        output high_time,
        output ratio_valid,
        output locked,
        output overflow
    );
endinterface : clk_ratio_meter_if

// File: rtl/clk_ratio_meter_rise_detect.sv
// Optional input synchronizer plus rising-edge detector for sig_in.
// RATIO_SYNC_EN: when defined, a 2-flop synchronizer is inserted ahead
// of the edge detect so the input may be asynchronous to clk.
module clk_ratio_meter_rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig_i,
    output logic level_c,
    output logic rise_c
);
    logic sig_s;
    logic sig_d_q;

`ifdef RATIO_SYNC_EN
    logic [1:0] sync_q;

    // Two-stage synchronizer for an asynchronous divided clock
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], sig_i};
        end
    end

    assign sig_s = sync_q[1];
`else
    assign sig_s = sig_i;
`endif

    // Previous-cycle level for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sig_d_q <= 1'b0;
        end else begin
            sig_d_q <= sig_s;
        end
    end

    assign level_c = sig_s;
    assign rise_c  = sig_s & ~sig_d_q;

endmodule : clk_ratio_meter_rise_detect

// File: rtl/clk_ratio_meter.sv
// Measures period and high time of a divided clock in clk cycles, with
// lock and overflow status. RATIO_SYNC_EN enables the input synchronizer
// inside the rise detector (adds two cycles to every event latency).
module clk_ratio_meter
    import clk_ratio_meter_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    clk_ratio_meter_if.slave   bus
);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic level_c;
    logic rise_c;

    rm_state_e        state_q,  state_d;
    logic [WIDTH-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] hcnt_q,   hcnt_d;
    logic [WIDTH-1:0] prev_q,   prev_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] high_q,   high_d;
    logic             valid_q,  valid_d;
    logic             locked_q, locked_d;
    logic             ovf_q,    ovf_d;

    clk_ratio_meter_rise_detect u_rise_detect (
        .clk     (clk),
        .reset   (reset),
        .sig_i   (bus.sig_in),
        .level_c (level_c),
        .rise_c  (rise_c)
    );

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RM_IDLE;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            prev_q   <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hcnt_q   <= hcnt_d;
            prev_q   <= prev_d;
            period_q <= period_d;
            high_q   <= high_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            ovf_q    <= ovf_d;
        end
    end

    // Saturating period/high counters restarted by each rising edge
    always_comb begin
        cnt_d  = cnt_q;
        hcnt_d = hcnt_q;
        if (rise_c) begin
            cnt_d  = CNT_ONE;
            hcnt_d = CNT_ONE;
        end else begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end
            if (level_c && (hcnt_q != CNT_MAX)) begin
                hcnt_d = hcnt_q + CNT_ONE;
            end
        end
    end

    // Measurement FSM: arm, publish on each rise, flag saturation
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        period_d = period_q;
        high_d   = high_q;
        valid_d  = 1'b0;
        locked_d = locked_q;
        ovf_d    = ovf_q;
        case (state_q)
            RM_IDLE: begin
                if (rise_c) begin
                    state_d = RM_MEASURE;
                end
            end
            RM_MEASURE: begin
                // A rise on the saturation cycle still yields a valid period
                if (rise_c) begin
                    period_d = cnt_q;
                    high_d   = hcnt_q;
                    valid_d  = 1'b1;
                    ovf_d    = 1'b0;
                    locked_d = (cnt_q == prev_q);
                    prev_d   = cnt_q;
                end else if (cnt_q == CNT_MAX) begin
                    state_d  = RM_OVF;
                    ovf_d    = 1'b1;
                    locked_d = 1'b0;
                end
            end
            RM_OVF: begin
                // The overflowed period is discarded; this rise re-arms only
                if (rise_c) begin
                    state_d = RM_MEASURE;
                end
            end
            default: begin
                state_d = RM_IDLE;
            end
        endcase
    end

    assign bus.period      = period_q;
    assign bus.high_time   = high_q;
    assign bus.ratio_valid = valid_q;
    assign bus.locked      = locked_q;
    assign bus.overflow    = ovf_q;

endmodule : clk_ratio_meter

// File: tb/tb_clk_ratio_meter.sv
// Directed bench for clk_ratio_meter (WIDTH=8).
module tb_clk_ratio_meter;

`ifdef RATIO_SYNC_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 0;
`endif

    logic clk;
    logic reset;

    clk_ratio_meter_if #(.WIDTH(8)) bus ();

    clk_ratio_meter #(.WIDTH(8)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc_n = 0;
    int unsigned vcnt = 0;
    int unsigned last_period = 0;
    int unsigned last_high = 0;
    int unsigned last_locked = 0;
    int unsigned last_valid_cyc = 0;
    int unsigned last_rise_cyc = 0;
    int unsigned ovf_cyc = 0;
    logic        ovf_prev = 1'b0;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned snap;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Capture every valid pulse and the first cycle overflow is seen
    always @(negedge clk) begin
        if (bus.ratio_valid === 1'b1) begin
            vcnt++;
            last_period    = 32'(bus.period);
            last_high      = 32'(bus.high_time);
            last_locked    = 32'(bus.locked);
            last_valid_cyc = cyc_n;
        end
        if (bus.overflow === 1'b1 && ovf_prev !== 1'b1) ovf_cyc = cyc_n;
        ovf_prev = bus.overflow;
    end

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.sig_in = v;
        end
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < hi + lo; i++) begin
                @(negedge clk);
                bus.sig_in = (i < hi);
                if (i == 0) last_rise_cyc = cyc_n + 1;
            end
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        bus.sig_in = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        settle();
        chk("rst_period", 32'(bus.period), 0);
        chk("rst_high", 32'(bus.high_time), 0);
        chk("rst_valid", 32'(bus.ratio_valid), 0);
        chk("rst_locked", 32'(bus.locked), 0);
        chk("rst_ovf", 32'(bus.overflow), 0);

        // 3 high / 3 low: first rise arms only
        wave(3, 3, 1); settle();
        chk("s1_arm_novalid", vcnt, 0);
        wave(3, 3, 1); settle();
        chk("s1_first_cnt", vcnt, 1);
        chk("s1_first_period", last_period, 6);
        chk("s1_first_high", last_high, 3);
        chk("s1_first_locked", last_locked, 0);
        chk("s1_latency", last_valid_cyc - last_rise_cyc, LAT);
        wave(3, 3, 3); settle();
        chk("s1_cnt", vcnt, 4);
        chk("s1_period_hold", 32'(bus.period), 6);
        chk("s1_high_hold", 32'(bus.high_time), 3);
        chk("s1_locked", 32'(bus.locked), 1);
        chk("s1_valid_low", 32'(bus.ratio_valid), 0);

        // Switch to 2 high / 2 low
        wave(2, 2, 1);
        wave(2, 2, 1); settle();
        chk("s2_period", last_period, 4);
        chk("s2_high", last_high, 2);
        chk("s2_unlocked", last_locked, 0);
        wave(2, 2, 1); settle();
        chk("s2_period2", last_period, 4);
        chk("s2_relocked", last_locked, 1);

        // Input stuck low: saturate into overflow
        snap = vcnt;
        hold(1'b0, 300); settle();
        chk("s3_ovf", 32'(bus.overflow), 1);
        chk("s3_locked", 32'(bus.locked), 0);
        chk("s3_novalid", vcnt, snap);
        chk("s3_ovf_time", ovf_cyc - last_rise_cyc, 255 + LAT);
        wave(3, 3, 1); settle();
        chk("s3_rearm_novalid", vcnt, snap);
        chk("s3_ovf_sticky", 32'(bus.overflow), 1);
        wave(3, 3, 1); settle();
        chk("s3_recover_cnt", vcnt, snap + 1);
        chk("s3_recover_period", last_period, 6);
        chk("s3_ovf_clear", 32'(bus.overflow), 0);

        // Rise exactly on saturation: valid period 255, stays measuring
        wave(1, 254, 1);
        snap = vcnt;
        wave(1, 5, 1); settle();
        chk("sat_cnt", vcnt, snap + 1);
        chk("sat_period", last_period, 255);
        chk("sat_high", last_high, 1);
        chk("sat_no_ovf", 32'(bus.overflow), 0);
        wave(1, 5, 1); settle();
        chk("sat_next_cnt", vcnt, snap + 2);
        chk("sat_next_period", last_period, 6);

        // Period 10, reset mid-period
        wave(5, 5, 2);
        hold(1'b1, 3);
        @(negedge clk);
        reset = 1'b1;
        bus.sig_in = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("s4_rst_period", 32'(bus.period), 0);
        chk("s4_rst_high", 32'(bus.high_time), 0);
        chk("s4_rst_locked", 32'(bus.locked), 0);
        snap = vcnt;
        hold(1'b0, 5);
        wave(5, 5, 1); settle();
        chk("s4_arm_novalid", vcnt, snap);
        wave(5, 5, 1); settle();
        chk("s4_cnt", vcnt, snap + 1);
        chk("s4_period", last_period, 10);
        chk("s4_high", last_high, 5);
        chk("s4_locked", last_locked, 0);

        // Minimum period toggle
        wave(1, 1, 6);
        hold(1'b0, 3); settle();
        chk("s5_period", last_period, 2);
        chk("s5_high", last_high, 1);
        chk("s5_locked", last_locked, 1);
        chk("s5_cnt", vcnt, snap + 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_clk_ratio_meter
